enigma_host_driver: RTL and testbench

ENIGMA_HOST_DRIVER -- requirements
Module: enigma_host_driver

---
 rtl/enigma_host_driver.sv | 200 ++++++++++++++++++++
 tb/tb_enigma_host_driver.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_host_driver.sv
// Host-side driver for an Enigma cipher core.
// Accepts ASCII bytes from a host, sends letters to the core as ENCRYPT
// commands and passes other bytes straight through. Returns the result with
// the original letter case. Also loads the three rotor start positions on
// request.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready      host byte handshake, in_data = ASCII byte
//   out_valid/out_ready    result handshake, out_data = ASCII byte
//   cfg_start, cfg_pos     start a rotor load, positions {r2,r1,r0}
//   cfg_busy               high while the rotor load runs
//   core_cmd, core_resp    cipher core command {op,operand} / response {ack,letter}
//   timeout_err            sticky error, cleared only by reset
module enigma_host_driver #(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  input  logic        cfg_start,
  input  logic [14:0] cfg_pos,
  output logic        cfg_busy,
  output logic [7:0]  core_cmd,
  input  logic [5:0]  core_resp,
  output logic        timeout_err
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned POS_W  = 5;

  localparam logic [2:0] OP_ENC = 3'b001;
  localparam logic [2:0] OP_R0  = 3'b010;
  localparam logic [2:0] OP_R1  = 3'b011;
  localparam logic [2:0] OP_R2  = 3'b100;

  localparam logic [DATA_W-1:0] ERR_CHAR = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_EMIT, S_CFG_ISSUE, S_CFG_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [7:0]        core_cmd_q, core_cmd_d;
  logic              cfg_busy_q, cfg_busy_d;
  logic              timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              upper_q, upper_d;
  logic [1:0]        idx_q, idx_d;
  logic [14:0]       pos_q, pos_d;

  logic              ack;
  logic [POS_W-1:0]  letter;
  logic              cnt_last;
  logic              is_upper, is_lower;

  // Rotor fields are 5 bits, so one subtraction brings 26..31 into range.
  function automatic logic [POS_W-1:0] mod26(input logic [POS_W-1:0] p);
    return (p > 5'd25) ? POS_W'(p - 5'd26) : p;
  endfunction

  assign ack      = core_resp[5];
  assign letter   = core_resp[4:0];
  assign cnt_last = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign is_upper = (in_data >= 8'h41) && (in_data <= 8'h5A);
  assign is_lower = (in_data >= 8'h61) && (in_data <= 8'h7A);

  // cfg_start wins over a same-cycle host byte, so ready drops with it.
  assign in_ready    = in_ready_q & ~cfg_start;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign cfg_busy    = cfg_busy_q;
  assign core_cmd    = core_cmd_q;
  assign timeout_err = timeout_err_q;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      core_cmd_q    <= '0;
      cfg_busy_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
      upper_q       <= 1'b0;
      idx_q         <= '0;
      pos_q         <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      core_cmd_q    <= core_cmd_d;
      cfg_busy_q    <= cfg_busy_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
      upper_q       <= upper_d;
      idx_q         <= idx_d;
      pos_q         <= pos_d;
    end
  end

  // Next-state and next-output logic; core_cmd is NOP unless entering an issue state.
  always_comb begin
    state_d       = state_q;
    out_data_d    = out_data_q;
    core_cmd_d    = '0;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;
    upper_d       = upper_q;
    idx_d         = idx_q;
    pos_d         = pos_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          pos_d      = {mod26(cfg_pos[14:10]), mod26(cfg_pos[9:5]), mod26(cfg_pos[4:0])};
          idx_d      = '0;
          core_cmd_d = {OP_R0, mod26(cfg_pos[4:0])};
          state_d    = S_CFG_ISSUE;
        end else if (in_valid && in_ready_q) begin
          if (is_upper) begin
            upper_d    = 1'b1;
            core_cmd_d = {OP_ENC, POS_W'(in_data - 8'h41)};
            state_d    = S_ISSUE;
          end else if (is_lower) begin
            upper_d    = 1'b0;
            core_cmd_d = {OP_ENC, POS_W'(in_data - 8'h61)};
            state_d    = S_ISSUE;
          end else begin
            out_data_d = in_data;
            state_d    = S_EMIT;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // An ack in the final allowed cycle still counts.
        if (ack) begin
          if (letter > 5'd25) begin
            timeout_err_d = 1'b1;
            out_data_d    = ERR_CHAR;
          end else begin
            out_data_d = (upper_q ? 8'h41 : 8'h61) + DATA_W'(letter);
          end
          state_d = S_EMIT;
        end else if (cnt_last) begin
          timeout_err_d = 1'b1;
          out_data_d    = ERR_CHAR;
          state_d       = S_EMIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EMIT: begin
        if (out_ready) state_d = S_IDLE;
      end
      S_CFG_ISSUE: begin
        cnt_d   = '0;
        state_d = S_CFG_WAIT;
      end
      S_CFG_WAIT: begin
        if (ack) begin
          if (idx_q == 2'd2) begin
            state_d = S_IDLE;
          end else begin
            idx_d      = idx_q + 2'd1;
            core_cmd_d = (idx_q == 2'd0) ? {OP_R1, pos_q[9:5]} : {OP_R2, pos_q[14:10]};
            state_d    = S_CFG_ISSUE;
          end
        end else if (cnt_last) begin
          // Abort the remaining loads.
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready_d  = (state_d == S_IDLE);
  assign out_valid_d = (state_d == S_EMIT);
  assign cfg_busy_d  = (state_d == S_CFG_ISSUE) || (state_d == S_CFG_WAIT);

endmodule

// File: tb/tb_enigma_host_driver.sv
// Self-checking bench for enigma_host_driver: directed vector table, rotor
// load sequences, reset corner cases and a randomized run against a
// reference model derived from the byte/rotor rules.
module tb_enigma_host_driver;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        cfg_start = 1'b0;
  logic [14:0] cfg_pos = 15'd0;
  logic        cfg_busy;
  logic [7:0]  core_cmd;
  logic [5:0]  core_resp = 6'd0;
  logic        timeout_err;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic err_exp = 1'b0;

  always #5 clk = ~clk;

  enigma_host_driver #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .cfg_start(cfg_start), .cfg_pos(cfg_pos), .cfg_busy(cfg_busy),
    .core_cmd(core_cmd), .core_resp(core_resp), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [7:0] b;
    int         dly;     // WAIT cycle carrying the ack, 0 = never
    logic [4:0] letter;
    int         rdy;     // cycles out_ready is held low in EMIT
    logic [7:0] e_data;
    int         e_lat;   // cycles from accept edge to first out_valid
    logic [7:0] e_cmd;   // 0 = no command expected
    logic       e_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: what the host should see for one byte.
  function automatic void model_byte(input logic [7:0] b, input int dly, input logic [4:0] letter,
                                     output logic [7:0] data, output int lat,
                                     output logic [7:0] cmd, output logic err);
    int base;
    bit up, lo;
    up = (b >= "A") && (b <= "Z");
    lo = (b >= "a") && (b <= "z");
    err = 1'b0;
    if (!up && !lo) begin
      data = b; lat = 1; cmd = 8'h00;
    end else begin
      base = up ? 65 : 97;
      cmd  = 8'(32 + (int'(b) - base));
      if (dly == 0 || dly > int'(TO)) begin
        data = "?"; lat = int'(TO) + 2; err = 1'b1;
      end else if (letter > 25) begin
        data = "?"; lat = dly + 2; err = 1'b1;
      end else begin
        data = 8'(base + int'(letter)); lat = dly + 2;
      end
    end
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; cfg_start = 1'b0; out_ready = 1'b0; core_resp = '0;
    repeat (2) @(negedge clk);
    check("rst_state", {in_ready, out_valid, out_data, core_cmd, cfg_busy, timeout_err},
          {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
    rst_n = 1'b1;
    @(negedge clk);
    err_exp = 1'b0;
    check("rst_release_ready", in_ready, 1);
  endtask

  // One host byte end to end; starts and ends at a negedge in IDLE.
  task automatic run_byte(input logic [7:0] b, input int dly, input logic [4:0] letter,
                          input int rdy, input bit spur, input logic [7:0] e_data,
                          input int e_lat, input logic [7:0] e_cmd, input logic e_err);
    int lat, ncmd;
    logic [7:0] cmd_v, d0;
    bit hold_ok;
    lat = -1; ncmd = 0; cmd_v = 8'h00; hold_ok = 1'b1;
    check("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = b;
    @(posedge clk);
    for (int c = 1; c <= int'(TO) + 8; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (out_valid) begin lat = c; break; end
      if (core_cmd != 8'h00) begin ncmd++; cmd_v = core_cmd; end
      if (c == 1) core_resp = spur ? {1'b1, letter ^ 5'd7} : 6'd0;
      else        core_resp = (c == dly + 1) ? {1'b1, letter} : 6'd0;
    end
    core_resp = '0;
    check("latency", lat, e_lat);
    check("out_data", out_data, e_data);
    check("cmd_cycles", ncmd, (e_cmd != 8'h00) ? 1 : 0);
    check("cmd_value", cmd_v, e_cmd);
    check("timeout_err", timeout_err, e_err);
    d0 = out_data;
    for (int i = 0; i < rdy; i++) begin
      if (i == 0) begin cfg_start = 1'b1; cfg_pos = 15'($urandom); end
      @(negedge clk);
      cfg_start = 1'b0;
      if (!out_valid || out_data != d0 || in_ready || core_cmd != 8'h00 || cfg_busy) hold_ok = 1'b0;
    end
    if (rdy > 0) check("emit_hold", hold_ok, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_handshake", {out_valid, in_ready, cfg_busy, core_cmd}, {1'b0, 1'b1, 1'b0, 8'h00});
  endtask

  // One rotor load sequence; d[k] is the CFG_WAIT cycle carrying the ack.
  task automatic run_cfg(input logic [14:0] pos, input int d0, input int d1, input int d2,
                         input bit with_byte);
    int d[3];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int exp_end, end_c, w, j, p;
    logic e_err;
    bit ok;
    d = '{d0, d1, d2};
    exp_end = 1; e_err = err_exp;
    for (int k = 0; k < 3; k++) begin
      p = (int'(pos) >> (5 * k)) & 31;
      exp_q.push_back(8'((2 + k) * 32 + p % 26));
      if (d[k] == 0 || d[k] > int'(TO)) begin
        exp_end += 1 + int'(TO); e_err = 1'b1; break;
      end
      exp_end += 1 + d[k];
    end
    check("cfg_idle_ready", in_ready, 1);
    cfg_start = 1'b1; cfg_pos = pos;
    if (with_byte) begin in_valid = 1'b1; in_data = "K"; end
    #1;
    if (with_byte) check("cfg_priority_ready", in_ready, 0);
    @(posedge clk);
    end_c = -1; w = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin cfg_start = 1'b0; in_valid = 1'b0; end
      if (!cfg_busy) begin end_c = c; break; end
      if (core_cmd != 8'h00) begin
        got_q.push_back(core_cmd); w = 0; core_resp = '0;
      end else begin
        w++;
        j = got_q.size() - 1;
        core_resp = (j >= 0 && j < 3 && w == d[j]) ? {1'b1, 5'($urandom % 26)} : 6'd0;
      end
    end
    core_resp = '0;
    err_exp = e_err;
    check("cfg_end_cycle", end_c, exp_end);
    check("cfg_cmd_count", got_q.size(), exp_q.size());
    ok = (got_q.size() == exp_q.size());
    if (ok) foreach (exp_q[k]) if (got_q[k] != exp_q[k]) ok = 1'b0;
    check("cfg_cmds", ok, 1);
    check("cfg_err", timeout_err, err_exp);
    check("cfg_done_idle", {in_ready, out_valid}, {1'b1, 1'b0});
  endtask

  vec_t tbl[9];

  initial begin
    logic [7:0] b, e_data, e_cmd;
    logic [4:0] letter;
    int dly, rdy, e_lat, quiet;
    logic e_err;

    tbl[0] = '{8'h48, 1, 5'd5,  0,  8'h46, 3, 8'h27, 1'b0}; // 'H' -> 'F'
    tbl[1] = '{8'h68, 1, 5'd0,  2,  8'h61, 3, 8'h27, 1'b0}; // 'h' -> 'a'
    tbl[2] = '{8'h20, 0, 5'd0,  1,  8'h20, 1, 8'h00, 1'b0}; // space passes through
    tbl[3] = '{8'h7A, 2, 5'd25, 0,  8'h7A, 4, 8'h39, 1'b0}; // 'z', top letter
    tbl[4] = '{8'h4D, 4, 5'd12, 0,  8'h4D, 6, 8'h2C, 1'b0}; // ack on the last allowed cycle
    tbl[5] = '{8'h30, 0, 5'd0,  0,  8'h30, 1, 8'h00, 1'b0}; // digit passes through
    tbl[6] = '{8'h41, 0, 5'd0,  10, 8'h3F, 6, 8'h20, 1'b1}; // no ack -> '?', long stall
    tbl[7] = '{8'h62, 1, 5'd27, 0,  8'h3F, 3, 8'h21, 1'b1}; // bad letter -> '?'
    tbl[8] = '{8'h51, 5, 5'd3,  1,  8'h3F, 6, 8'h30, 1'b1}; // ack one cycle too late

    do_reset();
    for (int i = 0; i < 9; i++) begin
      run_byte(tbl[i].b, tbl[i].dly, tbl[i].letter, tbl[i].rdy, 1'b0,
               tbl[i].e_data, tbl[i].e_lat, tbl[i].e_cmd, tbl[i].e_err);
      err_exp = tbl[i].e_err;
    end

    // Rotor load with position 28 folded to 2, same-cycle host byte refused.
    do_reset();
    run_cfg({5'd2, 5'd1, 5'd28}, 2, 1, 3, 1'b1);
    run_cfg({5'd31, 5'd26, 5'd7}, 1, 0, 1, 1'b0);

    // Reset while a result is stalled in EMIT.
    do_reset();
    in_valid = 1'b1; in_data = "A";
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); core_resp = {1'b1, 5'd1};
    @(negedge clk); core_resp = '0;
    check("emit_before_rst", {out_valid, out_data}, {1'b1, 8'h42});
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_emit", {out_valid, in_ready, core_cmd}, {1'b0, 1'b0, 8'h00});
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_emit_ready", in_ready, 1);

    // Reset while waiting for the core; a late ack must produce nothing.
    in_valid = 1'b1; in_data = "c";
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      core_resp = {1'b1, 5'd4};
      @(negedge clk);
      if (out_valid || core_cmd != 8'h00 || timeout_err) quiet++;
    end
    core_resp = '0;
    check("rst_mid_wait_quiet", quiet, 0);
    check("rst_mid_wait_ready", in_ready, 1);
    err_exp = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 80; n++) begin
      if ($urandom % 8 == 0) begin
        run_cfg(15'($urandom), $urandom_range(0, 5), $urandom_range(1, 5),
                $urandom_range(0, 5), 1'($urandom % 2));
      end else begin
        case ($urandom % 3)
          0:       b = 8'(65 + $urandom % 26);
          1:       b = 8'(97 + $urandom % 26);
          default: begin
            b = 8'($urandom);
            if ((b >= "A" && b <= "Z") || (b >= "a" && b <= "z")) b = b & 8'h3F;
          end
        endcase
        dly    = $urandom % 7;
        letter = ($urandom % 5 == 0) ? 5'(26 + $urandom % 6) : 5'($urandom % 26);
        rdy    = $urandom % 4;
        model_byte(b, dly, letter, e_data, e_lat, e_cmd, e_err);
        e_err = e_err | err_exp;
        run_byte(b, dly, letter, rdy, 1'($urandom % 2), e_data, e_lat, e_cmd, e_err);
        err_exp = e_err;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
